// File: rtl/ysyx_23060072_dmem.sv
// Single-port data memory behind a valid/ready request/response handshake.
// A fixed-latency IDLE/WAIT/RESP sequencer holds each response until the LSU takes it.
module ysyx_23060072_dmem #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned AW        = 10,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wmask_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = 4;
  // Window size in bytes, one bit wider so the compare cannot wrap.
  localparam logic [32:0] SPAN  = 33'(1) << (AW + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     mem_q [DEPTH];

  logic            accept_c;
  logic [31:0]     offset_c;
  logic            in_range_c;
  logic [AW-1:0]   index_c;
  logic            wr_en_c;

  // Request decode; no accepts while reset is held so memory stays untouched.
  assign accept_c   = rst_n && req_valid_i && req_ready_q;
  assign offset_c   = req_addr_i - BASE_ADDR;
  assign in_range_c = {1'b0, offset_c} < SPAN;
  assign index_c    = req_addr_i[AW+1:2];
  assign wr_en_c    = accept_c && req_wen_i && in_range_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (LATENCY <= 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Handshake flags track the next state; the payload is captured once at accept.
  always_comb begin
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (accept_c) begin
      rsp_err_d   = !in_range_c;
      rsp_rdata_d = (!req_wen_i && in_range_c) ? mem_q[index_c] : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int n = 0; n < 4; n++) begin
        if (req_wmask_i[n]) begin
          mem_q[index_c][8*n +: 8] <= req_wdata_i[8*n +: 8];
        end
      end
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_ysyx_23060072_dmem.sv
// Scoreboard bench: instance 0 runs LATENCY=1, instance 1 runs LATENCY=4.
// Expected responses are queued at issue time and popped by a monitor on each response handshake.
module tb_ysyx_23060072_dmem;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wen   [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wmask [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   checks;
  int   failures;

  ysyx_23060072_dmem #(.LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_wen_i(req_wen[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_wmask_i(req_wmask[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
  );

  ysyx_23060072_dmem #(.LATENCY(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_wen_i(req_wen[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_wmask_i(req_wmask[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int qsz(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic push(input int d, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.rdata = rdata;
    e.err   = err;
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Monitor: a response is consumed on the next edge whenever valid and ready are both high.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid[0] === 1'b1 && rsp_ready[0] === 1'b1) begin
      if (exp_q0.size() == 0) begin
        chk("unexpected_rsp0", 32'd1, 32'd0);
      end else begin
        e = exp_q0.pop_front();
        chk("rsp0_rdata", rsp_rdata[0], e.rdata);
        chk("rsp0_err", 32'(rsp_err[0]), 32'(e.err));
      end
    end
    if (rsp_valid[1] === 1'b1 && rsp_ready[1] === 1'b1) begin
      if (exp_q1.size() == 0) begin
        chk("unexpected_rsp1", 32'd1, 32'd0);
      end else begin
        e = exp_q1.pop_front();
        chk("rsp1_rdata", rsp_rdata[1], e.rdata);
        chk("rsp1_err", 32'(rsp_err[1]), 32'(e.err));
      end
    end
  end

  // Present one request for one edge (DUT must be idle); optionally queue its expected response.
  task automatic issue(input int d, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask,
                       input bit expect_rsp, input logic [31:0] e_rdata, input logic e_err);
    req_valid[d] = 1'b1;
    req_wen[d]   = wen;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_wmask[d] = mask;
    if (expect_rsp) push(d, e_rdata, e_err);
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_wdata[d] = 32'hX;
  endtask

  task automatic wait_done(input int d);
    for (int i = 0; i < 60; i++) begin
      if (qsz(d) == 0) break;
      @(posedge clk);
      #1;
    end
    if (qsz(d) != 0) begin
      checks++;
      failures++;
      $display("FAIL wait_done%0d: outstanding=%0d expected 0", d, qsz(d));
    end
  endtask

  task automatic xfer(input int d, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] mask,
                      input logic [31:0] e_rdata, input logic e_err);
    issue(d, wen, addr, wdata, mask, 1'b1, e_rdata, e_err);
    wait_done(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_wen[d]   = 1'b0;
      req_addr[d]  = 32'h0;
      req_wdata[d] = 32'h0;
      req_wmask[d] = 4'h0;
      rsp_ready[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", 32'(req_ready[d]), 32'd1);
      chk("reset_valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset_rdata", rsp_rdata[d], 32'h0);
      chk("reset_err", 32'(rsp_err[d]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // LATENCY=1: store responds one cycle after accept, then read back
    issue(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 1'b0);
    @(negedge clk);
    chk("lat1_valid", 32'(rsp_valid[0]), 32'd1);
    chk("lat1_ready_busy", 32'(req_ready[0]), 32'd0);
    wait_done(0);
    xfer(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);

    // Byte-lane merge and empty mask
    xfer(0, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
    xfer(0, 1'b1, 32'h8000_0010, 32'h00AA_0000, 4'b0100, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'h11AA_3344, 1'b0);
    xfer(0, 1'b1, 32'h8000_0012, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h8000_0013, 32'h0, 4'h0, 32'h11AA_3344, 1'b0);

    // Out-of-range: errors, and the aliasing top word is not written
    xfer(0, 1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(0, 1'b1, 32'h7FFF_FFFC, 32'h1234_5678, 4'hF, 32'h0, 1'b1);
    xfer(0, 1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);

    // Back-to-back with req_valid held high: second accept one cycle after the first response
    req_valid[0] = 1'b1;
    req_wen[0]   = 1'b0;
    req_addr[0]  = 32'h8000_0010;
    push(0, 32'h11AA_3344, 1'b0);
    push(0, 32'hCAFE_F00D, 1'b0);
    @(posedge clk);
    #1;
    req_addr[0] = 32'h8000_0FFC;
    @(negedge clk);
    chk("b2b_first_valid", 32'(rsp_valid[0]), 32'd1);
    @(negedge clk);
    chk("b2b_gap_ready", 32'(req_ready[0]), 32'd1);
    chk("b2b_gap_valid", 32'(rsp_valid[0]), 32'd0);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("b2b_second_valid", 32'(rsp_valid[0]), 32'd1);
    wait_done(0);

    // LATENCY=4 with a stalled response
    xfer(1, 1'b1, 32'h8000_0040, 32'h0BAD_F00D, 4'hF, 32'h0, 1'b0);
    rsp_ready[1] = 1'b0;
    issue(1, 1'b0, 32'h8000_0040, 32'h0, 4'h0, 1'b1, 32'h0BAD_F00D, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("lat4_valid_c%0d", k), 32'(rsp_valid[1]), 32'(k == 4));
      chk($sformatf("lat4_ready_c%0d", k), 32'(req_ready[1]), 32'd0);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall_valid_c%0d", k), 32'(rsp_valid[1]), 32'd1);
      chk($sformatf("stall_rdata_c%0d", k), rsp_rdata[1], 32'h0BAD_F00D);
      chk($sformatf("stall_ready_c%0d", k), 32'(req_ready[1]), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("stall_release_ready", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    chk("after_release_ready", 32'(req_ready[1]), 32'd1);
    chk("after_release_valid", 32'(rsp_valid[1]), 32'd0);
    wait_done(1);
    xfer(1, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1);

    // Reset while waiting: pending response dropped, committed store kept
    issue(1, 1'b1, 32'h8000_0080, 32'h5EED_F00D, 4'hF, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wait_valid", 32'(rsp_valid[1]), 32'd0);
    chk("rst_wait_ready", 32'(req_ready[1]), 32'd1);
    repeat (6) @(negedge clk);
    chk("rst_wait_no_rsp", 32'(rsp_valid[1]), 32'd0);
    @(posedge clk);
    #1;
    xfer(1, 1'b0, 32'h8000_0080, 32'h0, 4'h0, 32'h5EED_F00D, 1'b0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060072_dmem.md
YSYX_23060072_DMEM -- requirements
Module: ysyx_23060072_dmem

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter AW, default 10, word-index width; depth is 2^AW 32-bit words.
REQ-003 SHALL have parameter LATENCY, default 1, legal range 1..15, cycles from request acceptance to rsp_valid_o.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset: synchronous, active-low.
REQ-006 req_valid_i  input  1  LSU request valid.
REQ-007 req_ready_o  output  1  responder can accept a request.
REQ-008 req_wen_i  input  1  1 = store, 0 = load.
REQ-009 req_addr_i  input  32  byte address; bits [1:0] ignored, word index = addr[AW+1:2].
REQ-010 req_wdata_i  input  32  store data, already lane-aligned.
REQ-011 req_wmask_i  input  4  byte-lane write enables; bit n enables wdata[8n+7:8n].
REQ-012 rsp_valid_o  output  1  response valid.
REQ-013 rsp_ready_i  input  1  LSU accepts the response.
REQ-014 rsp_rdata_o  output  32  full aligned load word; 0 for stores and errors.
REQ-015 rsp_err_o  output  1  access fell outside [BASE_ADDR, BASE_ADDR + 4*2^AW).

Function
REQ-016 SHALL implement states IDLE, WAIT, RESP.
REQ-017 req_ready_o SHALL be 1 only in IDLE; rsp_valid_o SHALL be 1 only in RESP.
REQ-018 Accept SHALL occur on the edge where req_valid_i && req_ready_o.
REQ-019 On accept, with LATENCY==1, the FSM SHALL go IDLE->RESP; otherwise it SHALL go IDLE->WAIT and load cnt=LATENCY-1.
REQ-020 In WAIT, cnt SHALL decrement each cycle; at cnt==1 the FSM SHALL go to RESP.
REQ-021 rsp_valid_o SHALL therefore rise exactly LATENCY cycles after the accept edge.
REQ-022 In RESP, rsp_valid_o and rsp_rdata_o/rsp_err_o SHALL hold stable until rsp_ready_i is 1; that edge SHALL return the FSM to IDLE.
REQ-023 A new request SHALL NOT be accepted on the same edge that completes a response; the next accept is possible one cycle later.
REQ-024 Throughput with rsp_ready_i tied high is one access per LATENCY+1 cycles.
REQ-025 Range check SHALL be (addr - BASE_ADDR) < 4*2^AW, evaluated unsigned at accept.
REQ-026 An in-range store SHALL update only the lanes set in req_wmask_i, at the accept edge.
REQ-027 A store with wmask==4'b0000 SHALL leave memory unchanged and still respond with err=0, rdata=0.
REQ-028 An in-range load SHALL capture mem[index] into a response register at the accept edge.
REQ-029 An out-of-range access SHALL NOT write, SHALL return rdata=0, and SHALL set err=1.
REQ-030 Request inputs SHALL be ignored outside IDLE; they need not be held after accept.

Reset
REQ-031 While rst_n==0 at an edge: state=IDLE, cnt=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, req_ready_o=1 after the edge.
REQ-032 Reset in WAIT or RESP SHALL discard the pending response; a store already committed at accept SHALL remain in memory.
REQ-033 Memory contents SHALL NOT be reset.

Verification
REQ-034 LATENCY=1: store addr 8000_0010, data DEADBEEF, mask F -> rsp_valid 1 cycle later, err=0; then load 8000_0010 -> rdata=DEADBEEF.
REQ-035 Byte merge: memory word 0x11223344, store 8000_0010 data 0x00AA0000, mask 4'b0100 -> load returns 0x11AA3344.
REQ-036 LATENCY=4, rsp_ready_i held 0 for 3 cycles after rsp_valid: rsp_valid rises 4 cycles after accept; rdata is stable throughout; req_ready_o=0 until the cycle after rsp_ready_i.
REQ-037 Out of range: load 8000_1000 (AW=10) -> err=1, rdata=0; store 7FFF_FFFC -> err=1 and no memory change.
REQ-038 rst_n=0 asserted in WAIT after a store accept -> next cycle rsp_valid=0, req_ready=1; a subsequent load returns the stored word.
REQ-039 Back-to-back: req_valid held 1 across two loads with rsp_ready=1 -> the second accept occurs the cycle after the first response completes.
